// File: rtl/envelope_pkg.sv
// Shared types and helpers for the ADSR envelope generator.
// Also used by the ENVELOPE_EXP_DECAY_EN build.
package envelope_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  // Per-sample linear step: code 0 moves half of full scale, each code halves it.
  function automatic logic [31:0] inc(input logic [3:0] code, input int unsigned acc_bits);
    return 32'd1 << (acc_bits - 32'd1 - 32'(code));
  endfunction

  function automatic logic [7:0] sustain_level(input logic [3:0] code);
    return {code, code};
  endfunction

endpackage

// File: rtl/envelope_rate_lut.sv
// Maps a 4-bit rate code to an ACC_BITS-wide linear accumulator step.
module envelope_rate_lut
  import envelope_pkg::*;
#(
  parameter int unsigned ACC_BITS = 20
) (
  input  logic [3:0]          i_code,
  output logic [ACC_BITS-1:0] o_inc
);

  assign o_inc = ACC_BITS'(inc(i_code, ACC_BITS));

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope generator advancing once per sample_en strobe.
// `define ENVELOPE_EXP_DECAY_EN for exponential decay/release. The release rate port is named
// rel because release is a reserved word.
module envelope_adsr
  import envelope_pkg::*;
#(
  parameter int unsigned ACC_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       gate,
  input  logic [3:0] attack,
  input  logic [3:0] decay,
  input  logic [3:0] rel,
  input  logic [3:0] sustain,
  output logic [7:0] amplitude,
  output logic       busy
);

  localparam logic [ACC_BITS-1:0] ACC_FULL = {ACC_BITS{1'b1}};
  localparam logic [ACC_BITS-1:0] ACC_ZERO = {ACC_BITS{1'b0}};

  env_state_t          r_state;
  env_state_t          w_state_nxt;
  logic [ACC_BITS-1:0] r_acc;
  logic [ACC_BITS-1:0] w_acc_nxt;
  logic                r_gate_prev;
  logic [7:0]          r_amplitude;
  logic                r_busy;

  logic [ACC_BITS-1:0] w_inc_a;
  logic [ACC_BITS-1:0] w_inc_d;
  logic [ACC_BITS-1:0] w_inc_r;
  logic [ACC_BITS-1:0] w_sus;
  logic [ACC_BITS-1:0] w_dec_step;
  logic [ACC_BITS-1:0] w_rel_step;
  logic [ACC_BITS:0]   w_att_sum;
  logic [ACC_BITS:0]   w_dec_diff;
  logic [ACC_BITS:0]   w_rel_diff;
  logic [ACC_BITS-1:0] w_att_val;
  logic [ACC_BITS-1:0] w_rel_val;
  logic                w_rise;
  logic                w_fall;

  envelope_rate_lut #(.ACC_BITS(ACC_BITS)) u_lut_attack (.i_code(attack), .o_inc(w_inc_a));
  envelope_rate_lut #(.ACC_BITS(ACC_BITS)) u_lut_decay  (.i_code(decay),  .o_inc(w_inc_d));
  envelope_rate_lut #(.ACC_BITS(ACC_BITS)) u_lut_rel    (.i_code(rel),    .o_inc(w_inc_r));

  assign w_sus = {sustain_level(sustain), {(ACC_BITS-8){1'b0}}};

`ifdef ENVELOPE_EXP_DECAY_EN
  // Step shrinks with distance to target; the +1 guarantees the target is reached.
  function automatic logic [ACC_BITS-1:0] exp_step(input logic [ACC_BITS-1:0] acc,
                                                   input logic [ACC_BITS-1:0] tgt,
                                                   input logic [3:0]          code);
    logic [ACC_BITS-1:0] diff;
    diff = (acc > tgt) ? (acc - tgt) : ACC_ZERO;
    return (diff >> (4'd1 + {1'b0, code[3:1]})) + {{(ACC_BITS-1){1'b0}}, 1'b1};
  endfunction

  assign w_dec_step = exp_step(r_acc, w_sus, decay);
  assign w_rel_step = exp_step(r_acc, ACC_ZERO, rel);
`else
  assign w_dec_step = w_inc_d;
  assign w_rel_step = w_inc_r;
`endif

  // One extra bit catches attack overflow and decay/release underflow.
  assign w_att_sum  = {1'b0, r_acc} + {1'b0, w_inc_a};
  assign w_dec_diff = {1'b0, r_acc} - {1'b0, w_dec_step};
  assign w_rel_diff = {1'b0, r_acc} - {1'b0, w_rel_step};
  assign w_att_val  = w_att_sum[ACC_BITS] ? ACC_FULL : w_att_sum[ACC_BITS-1:0];
  assign w_rel_val  = w_rel_diff[ACC_BITS] ? ACC_ZERO : w_rel_diff[ACC_BITS-1:0];

  assign w_rise = gate & ~r_gate_prev;
  assign w_fall = ~gate & r_gate_prev;

  // Next state/level for a sample; gate edges take priority over rate-driven moves.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    if (w_rise && (r_state == ST_OFF || r_state == ST_RELEASE)) begin
      w_state_nxt = ST_ATTACK;
      w_acc_nxt   = w_att_val;
    end else if (w_fall && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                            r_state == ST_SUSTAIN)) begin
      w_state_nxt = ST_RELEASE;
      w_acc_nxt   = w_rel_val;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_acc_nxt = ACC_ZERO;
        end
        ST_ATTACK: begin
          w_acc_nxt = w_att_val;
          if (w_att_val == ACC_FULL) begin
            w_state_nxt = ST_DECAY;
          end else begin
            w_state_nxt = ST_ATTACK;
          end
        end
        ST_DECAY: begin
          if (w_dec_diff[ACC_BITS] || (w_dec_diff[ACC_BITS-1:0] <= w_sus)) begin
            w_acc_nxt   = w_sus;
            w_state_nxt = ST_SUSTAIN;
          end else begin
            w_acc_nxt   = w_dec_diff[ACC_BITS-1:0];
          end
        end
        ST_SUSTAIN: begin
          w_acc_nxt = w_sus;
        end
        ST_RELEASE: begin
          if (w_rel_diff[ACC_BITS] || (w_rel_diff[ACC_BITS-1:0] == ACC_ZERO)) begin
            w_acc_nxt   = ACC_ZERO;
            w_state_nxt = ST_OFF;
          end else begin
            w_acc_nxt   = w_rel_diff[ACC_BITS-1:0];
          end
        end
        default: begin
          w_acc_nxt   = ACC_ZERO;
          w_state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // State, level, gate history and registered outputs advance only on sample strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_OFF;
      r_acc       <= ACC_ZERO;
      r_gate_prev <= 1'b0;
      r_amplitude <= 8'd0;
      r_busy      <= 1'b0;
    end else if (sample_en) begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_gate_prev <= gate;
      r_amplitude <= w_acc_nxt[ACC_BITS-1 -: 8];
      r_busy      <= (w_state_nxt != ST_OFF);
    end
  end

  assign amplitude = r_amplitude;
  assign busy      = r_busy;

endmodule
